regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_e;

  localparam int XLEN_DEF     = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the RF write port: pipe writeback has priority, a 1-entry buffer holds a divider result
// (earliest write 1 cycle after capture, forced stall after MAX_WAIT losses). Macro RF_WAW_SQUASH_EN squashes WAW-superseded results.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wr_en,
  input  logic [REG_AW-1:0] pipe_wr_addr,
  input  logic [XLEN-1:0]   pipe_wr_data,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic [REG_AW-1:0] div_addr,
  input  logic [XLEN-1:0]   div_data,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_wr_addr,
  output logic [XLEN-1:0]   rf_wr_data,
  output logic              stall_req,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_addr
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [REG_AW-1:0] buf_addr_q, buf_addr_d;
  logic [XLEN-1:0]   buf_data_q, buf_data_d;

  logic pipe_act;
  logic use_buf;

  assign pipe_act = pipe_wr_en && (pipe_wr_addr != '0);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    case (state_q)
      ST_IDLE: begin
        // Results for x0 are accepted and dropped without touching the buffer.
        if (div_valid && (div_addr != '0)) begin
          state_d    = ST_PEND;
          wait_cnt_d = '0;
          buf_addr_d = div_addr;
          buf_data_d = div_data;
        end
      end
      ST_PEND: begin
        if (!pipe_act) begin
          state_d = ST_IDLE;
        end
`ifdef RF_WAW_SQUASH_EN
        else if (pipe_wr_addr == buf_addr_q) begin
          state_d = ST_IDLE;
        end
`endif
        else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
          if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
            state_d = ST_FORCE;
          end
        end
      end
      ST_FORCE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

  // Outputs are forced low while reset is asserted, including the pipe pass-through.
  assign use_buf    = (state_q == ST_FORCE) || ((state_q == ST_PEND) && !pipe_act);
  assign rf_wr_en   = !rst && (use_buf || pipe_act);
  assign rf_wr_addr = rst ? '0 : (use_buf ? buf_addr_q : pipe_wr_addr);
  assign rf_wr_data = rst ? '0 : (use_buf ? buf_data_q : pipe_wr_data);
  assign stall_req  = !rst && (state_q == ST_FORCE);
  assign div_ready  = !rst && (state_q == ST_IDLE);
  assign pend_valid = !rst && (state_q != ST_IDLE);
  assign pend_addr  = pend_valid ? buf_addr_q : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, corner sequences, randomized run vs reference model.
module tb_regfile_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 4;
  localparam int NV       = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_wr_en;
  logic [REG_AW-1:0] pipe_wr_addr;
  logic [XLEN-1:0]   pipe_wr_data;
  logic              div_valid;
  logic              div_ready;
  logic [REG_AW-1:0] div_addr;
  logic [XLEN-1:0]   div_data;
  logic              rf_wr_en;
  logic [REG_AW-1:0] rf_wr_addr;
  logic [XLEN-1:0]   rf_wr_data;
  logic              stall_req;
  logic              pend_valid;
  logic [REG_AW-1:0] pend_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .div_valid(div_valid), .div_ready(div_ready), .div_addr(div_addr), .div_data(div_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .stall_req(stall_req), .pend_valid(pend_valid), .pend_addr(pend_addr)
  );

  typedef struct {
    logic              pe;
    logic [REG_AW-1:0] pa;
    logic [XLEN-1:0]   pd;
    logic              dv;
    logic [REG_AW-1:0] da;
    logic [XLEN-1:0]   dd;
    logic              e_en;
    logic [REG_AW-1:0] e_addr;
    logic [XLEN-1:0]   e_data;
    logic              e_stall;
    logic              e_ready;
    logic              e_pend;
    logic [REG_AW-1:0] e_paddr;
  } vec_t;

  vec_t tbl [NV];

  // Reference model: at most one outstanding divider result and how many cycles it has lost to the pipe.
  bit                m_has;
  logic [REG_AW-1:0] m_addr;
  logic [XLEN-1:0]   m_data;
  int                m_losses;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                              input logic dv, input logic [4:0] da, input logic [31:0] dd,
                              input logic en, input logic [4:0] ea, input logic [31:0] ed,
                              input logic st, input logic rdy, input logic pv, input logic [4:0] paddr);
    vec_t v;
    v.pe = pe; v.pa = pa; v.pd = pd; v.dv = dv; v.da = da; v.dd = dd;
    v.e_en = en; v.e_addr = ea; v.e_data = ed; v.e_stall = st;
    v.e_ready = rdy; v.e_pend = pv; v.e_paddr = paddr;
    return v;
  endfunction

  task automatic drive(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic dv, input logic [4:0] da, input logic [31:0] dd);
    pipe_wr_en = pe; pipe_wr_addr = pa; pipe_wr_data = pd;
    div_valid = dv; div_addr = da; div_data = dd;
  endtask

  // Applies one cycle of stimulus, checks outputs against the model, then advances the model.
  task automatic step(input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic dv, input logic [4:0] da, input logic [31:0] dd, input string tag);
    logic              e_en, e_stall;
    logic [REG_AW-1:0] e_addr;
    logic [XLEN-1:0]   e_data;
    bit                act;
    @(negedge clk);
    drive(pe, pa, pd, dv, da, dd);
    #1;
    act = pe && (pa != 0);
    e_stall = 1'b0;
    chk({tag, ".ready"}, div_ready, !m_has);
    chk({tag, ".pend"}, pend_valid, m_has);
    chk({tag, ".paddr"}, pend_addr, m_has ? m_addr : 5'd0);
    if (!m_has) begin
      e_en = act; e_addr = pa; e_data = pd;
      if (dv && da != 0) begin
        m_has = 1; m_addr = da; m_data = dd; m_losses = 0;
      end
    end else if (m_losses == MAX_WAIT) begin
      e_stall = 1'b1; e_en = 1'b1; e_addr = m_addr; e_data = m_data; m_has = 0;
    end else if (!act) begin
      e_en = 1'b1; e_addr = m_addr; e_data = m_data; m_has = 0;
    end else begin
      e_en = 1'b1; e_addr = pa; e_data = pd; m_losses++;
`ifdef RF_WAW_SQUASH_EN
      if (pa == m_addr) m_has = 0;
`endif
    end
    chk({tag, ".stall"}, stall_req, e_stall);
    chk({tag, ".en"}, rf_wr_en, e_en);
    if (e_en) begin
      chk({tag, ".addr"}, rf_wr_addr, e_addr);
      chk({tag, ".data"}, rf_wr_data, e_data);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_has = 0; m_losses = 0; m_addr = '0; m_data = '0;
  endtask

  initial begin
    int pct;
    rst = 1'b1;
    drive(1, 5'd3, 32'h1111, 1, 5'd4, 32'h2222);
    #12;
    chk("reset.en", rf_wr_en, 0);
    chk("reset.ready", div_ready, 0);
    chk("reset.stall", stall_req, 0);
    chk("reset.pend", pend_valid, 0);
    chk("reset.paddr", pend_addr, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Idle capture/drain, starvation into FORCE with pipe retry, then x0 filtering.
    tbl[0]  = mk(0, 0, 0,     1, 5, 32'h12345678, 0, 0, 0,            0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0,     0, 0, 0,            1, 5, 32'h12345678, 0, 0, 1, 5);
    tbl[2]  = mk(0, 0, 0,     0, 0, 0,            0, 0, 0,            0, 1, 0, 0);
    tbl[3]  = mk(1, 3, 32'h33, 1, 9, 32'hDEAD0009, 1, 3, 32'h33,      0, 1, 0, 0);
    tbl[4]  = mk(1, 3, 32'h34, 0, 0, 0,           1, 3, 32'h34,       0, 0, 1, 9);
    tbl[5]  = mk(1, 3, 32'h35, 0, 0, 0,           1, 3, 32'h35,       0, 0, 1, 9);
    tbl[6]  = mk(1, 3, 32'h36, 0, 0, 0,           1, 3, 32'h36,       0, 0, 1, 9);
    tbl[7]  = mk(1, 3, 32'h37, 0, 0, 0,           1, 3, 32'h37,       0, 0, 1, 9);
    tbl[8]  = mk(1, 3, 32'h38, 0, 0, 0,           1, 9, 32'hDEAD0009, 1, 0, 1, 9);
    tbl[9]  = mk(1, 3, 32'h38, 0, 0, 0,           1, 3, 32'h38,       0, 1, 0, 0);
    tbl[10] = mk(1, 0, 32'h55, 1, 0, 32'h66,      0, 0, 0,            0, 1, 0, 0);
    tbl[11] = mk(0, 0, 0,     0, 0, 0,            0, 0, 0,            0, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].pe, tbl[i].pa, tbl[i].pd, tbl[i].dv, tbl[i].da, tbl[i].dd);
      #1;
      chk($sformatf("vec%0d.en", i), rf_wr_en, tbl[i].e_en);
      if (tbl[i].e_en) begin
        chk($sformatf("vec%0d.addr", i), rf_wr_addr, tbl[i].e_addr);
        chk($sformatf("vec%0d.data", i), rf_wr_data, tbl[i].e_data);
      end
      chk($sformatf("vec%0d.stall", i), stall_req, tbl[i].e_stall);
      chk($sformatf("vec%0d.ready", i), div_ready, tbl[i].e_ready);
      chk($sformatf("vec%0d.pend", i), pend_valid, tbl[i].e_pend);
      chk($sformatf("vec%0d.paddr", i), pend_addr, tbl[i].e_paddr);
    end

    reset_dut();

    // Backpressure: second result held until the first IDLE cycle after the drain.
    step(1, 3, 32'h1, 1, 6, 32'h66, "bp0");
    step(1, 3, 32'h2, 1, 10, 32'h1010, "bp1");
    chk("bp.blocked", div_ready, 0);
    step(0, 0, 0, 1, 10, 32'h1010, "bp2");
    chk("bp.drain_addr", rf_wr_addr, 6);
    chk("bp.drain_ready", div_ready, 0);
    step(0, 0, 0, 1, 10, 32'h1010, "bp3");
    chk("bp.accept", div_ready, 1);
    step(0, 0, 0, 0, 0, 0, "bp4");
    chk("bp.second_write", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 5'd10, 32'h1010});

    // Same-destination pipe write while x7 is buffered.
    step(0, 0, 0, 1, 7, 32'h77, "waw0");
    step(1, 7, 32'hAA, 0, 0, 0, "waw1");
    chk("waw.pipe_write", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 5'd7, 32'hAA});
    step(0, 0, 0, 0, 0, 0, "waw2");
`ifdef RF_WAW_SQUASH_EN
    chk("waw.squashed", rf_wr_en, 0);
`else
    chk("waw.buffer_later", {rf_wr_en, rf_wr_addr, rf_wr_data}, {1'b1, 5'd7, 32'h77});
`endif
    step(0, 0, 0, 0, 0, 0, "waw3");

    // Reset while a result is buffered: outputs drop at once, result is lost.
    step(1, 3, 32'h9, 1, 8, 32'h88, "rp0");
    @(negedge clk);
    drive(1, 3, 32'hA, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rstpend.en", rf_wr_en, 0);
    chk("rstpend.stall", stall_req, 0);
    chk("rstpend.pend", pend_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    m_has = 0; m_losses = 0;
    step(0, 0, 0, 0, 0, 0, "rp1");
    step(0, 0, 0, 0, 0, 0, "rp2");

    // Randomized traffic with alternating busy and quiet pipe phases.
    for (int c = 0; c < 3000; c++) begin
      pct = ((c / 64) % 2 == 0) ? 92 : 40;
      step($urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
           $sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
